// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: strobes rows one-hot, images the synchronised column
// returns into a frame, classifies each frame, debounces the result and
// presents single-key press events over a valid/ready handshake.
module keypad_scanner #(
   parameter int unsigned ROWS     = 4,
   parameter int unsigned COLS     = 4,
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEBOUNCE = 4,
   localparam int unsigned CODE_W  = $clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ROWS-1:0]   row_drive,
   input  logic [COLS-1:0]   col_sense,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              multi_key,
   output logic              overrun
);

   localparam int unsigned KEYS  = ROWS * COLS;
   localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [DIV_W-1:0] LAST_DWELL = DIV_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_TARGET  = DB_W'(DEBOUNCE);

   typedef enum logic {
      SCAN = 1'b0,
      EVAL = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_SINGLE = 2'd1,
      RES_MULTI  = 2'd2
   } res_t;

   state_t            state, state_nx;
   logic [ROW_W-1:0]  row_idx, row_nx;
   logic [DIV_W-1:0]  dwell, dwell_nx;
   logic [ROWS-1:0]   row_drive_nx;
   logic              sample;

   logic [COLS-1:0]   sync1, sync2;
   logic [KEYS-1:0]   frame;

   res_t              res_cls;
   logic [CODE_W-1:0] res_code;
   logic [1:0]        ones;
   logic [CODE_W-1:0] first_code;

   res_t              cand_cls, stable_cls;
   logic [CODE_W-1:0] cand_code, stable_code;
   logic [DB_W-1:0]   db_cnt, cnt_nx;
   logic              same_cand;
   logic              accept;
   logic              press;

   // Scan sequencer state register; row_drive is registered alongside it
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SCAN;
         row_idx   <= '0;
         dwell     <= '0;
         row_drive <= ROWS'(1);
      end else begin
         state     <= state_nx;
         row_idx   <= row_nx;
         dwell     <= dwell_nx;
         row_drive <= row_drive_nx;
      end
   end

   // Next scan position, row strobe and frame-sample strobe
   always_comb begin
      state_nx     = state;
      row_nx       = row_idx;
      dwell_nx     = dwell + DIV_W'(1);
      sample       = 1'b0;
      row_drive_nx = '0;
      case (state)
         SCAN: begin
            if (dwell == LAST_DWELL) begin
               sample   = 1'b1;
               dwell_nx = '0;
               if (row_idx == LAST_ROW) begin
                  state_nx = EVAL;
                  row_nx   = '0;
               end else begin
                  row_nx = row_idx + ROW_W'(1);
               end
            end
         end
         EVAL: begin
            state_nx = SCAN;
            row_nx   = '0;
            dwell_nx = '0;
         end
         default: begin
            state_nx = SCAN;
            row_nx   = '0;
            dwell_nx = '0;
         end
      endcase
      for (int r = 0; r < ROWS; r++) begin
         row_drive_nx[r] = (state_nx == SCAN) && (row_nx == ROW_W'(r));
      end
   end

   // Classify the frame image: count closed keys (saturating at two), note the first
   always_comb begin
      ones       = 2'd0;
      first_code = '0;
      for (int i = 0; i < KEYS; i++) begin
         if (frame[i]) begin
            if (ones == 2'd0) first_code = CODE_W'(i);
            if (ones != 2'd2) ones = ones + 2'd1;
         end
      end
      res_cls  = RES_NONE;
      res_code = '0;
      if (ones == 2'd1) begin
         res_cls  = RES_SINGLE;
         res_code = first_code;
      end else if (ones == 2'd2) begin
         res_cls = RES_MULTI;
      end
   end

   // Debounce decision: a result becomes stable after DEBOUNCE identical frames
   always_comb begin
      same_cand = (res_cls == cand_cls) && (res_code == cand_code);
      cnt_nx    = DB_W'(1);
      if (same_cand) begin
         cnt_nx = (db_cnt == DB_TARGET) ? db_cnt : db_cnt + DB_W'(1);
      end
      accept = (state == EVAL) && (cnt_nx == DB_TARGET) &&
               ((res_cls != stable_cls) || (res_code != stable_code));
      press  = accept && (res_cls == RES_SINGLE);
   end

   // Column synchroniser, frame capture, debounce history and event handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1       <= '0;
         sync2       <= '0;
         frame       <= '0;
         cand_cls    <= RES_NONE;
         cand_code   <= '0;
         db_cnt      <= '0;
         stable_cls  <= RES_NONE;
         stable_code <= '0;
         multi_key   <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         overrun     <= 1'b0;
      end else begin
         sync1   <= col_sense;
         sync2   <= sync1;
         overrun <= 1'b0;
         if (sample) begin
            for (int r = 0; r < ROWS; r++) begin
               if (row_idx == ROW_W'(r)) frame[r*COLS +: COLS] <= sync2;
            end
         end
         if (state == EVAL) begin
            cand_cls  <= res_cls;
            cand_code <= res_code;
            db_cnt    <= cnt_nx;
         end
         if (accept) begin
            stable_cls  <= res_cls;
            stable_code <= res_code;
            multi_key   <= (res_cls == RES_MULTI);
         end
         if (press) begin
            if (!key_valid || key_ready) begin
               key_valid <= 1'b1;
               key_code  <= res_code;
            end else begin
               overrun <= 1'b1;
            end
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: an ideal keypad matrix answers the
// row strobes, a frame-level reference model predicts every output each cycle.
module tb_keypad_scanner;

   localparam int ROWS     = 4;
   localparam int COLS     = 4;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 2;
   localparam int PERIOD   = ROWS * SCAN_DIV + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_drive;
   logic [3:0]  col_sense;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ready;
   logic        multi_key;
   logic        overrun;

   logic [15:0] pressed;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (results: -1 none, -2 multi, else key code)
   int          m_cyc;
   int          hist[$];
   int          m_stable;
   logic        m_kv;
   logic [3:0]  m_kc;
   logic        m_ovr;
   logic        m_multi;

   typedef struct {
      logic [15:0] pressed;
      logic [1:0]  rdy;
      logic        exp_valid;
      logic [3:0]  exp_code;
      logic        exp_multi;
      logic        exp_ovr;
   } vec_t;

   vec_t tbl[22];

   keypad_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_drive (row_drive),
      .col_sense (col_sense),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .multi_key (multi_key),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Ideal keypad: a closed key connects its row strobe to its column
   always_comb begin
      col_sense = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_drive[r]) col_sense = col_sense | pressed[r*COLS +: COLS];
      end
   end

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int classify(input logic [15:0] p);
      int idx = 0;
      if ($countones(p) == 0) return -1;
      if ($countones(p) > 1) return -2;
      for (int i = 0; i < 16; i++) if (p[i]) idx = i;
      return idx;
   endfunction

   function automatic logic [3:0] exp_rows(input int cyc);
      int p = cyc % PERIOD;
      logic [3:0] one = 4'b0001;
      if (p < ROWS * SCAN_DIV) return one << (p / SCAN_DIV);
      return 4'b0000;
   endfunction

   task automatic model_reset();
      m_cyc    = 0;
      hist.delete();
      m_stable = -1;
      m_kv     = 1'b0;
      m_kc     = 4'd0;
      m_ovr    = 1'b0;
      m_multi  = 1'b0;
   endtask

   // Advance the model across one rising edge with key_ready = rdy
   task automatic model_edge(input logic rdy);
      logic ev = 1'b0;
      logic nov = 1'b0;
      int   r = -1;
      bit   all_same;
      if (m_cyc % PERIOD == PERIOD - 1) begin
         r = classify(pressed);
         hist.push_back(r);
         if (hist.size() > DEB) void'(hist.pop_front());
         all_same = (hist.size() == DEB);
         foreach (hist[i]) if (hist[i] != r) all_same = 0;
         if (all_same && r != m_stable) begin
            m_stable = r;
            ev = (r >= 0);
         end
      end
      m_multi = (m_stable == -2);
      if (ev) begin
         if (!m_kv || rdy) begin
            m_kv = 1'b1;
            m_kc = 4'(r);
         end else begin
            nov = 1'b1;
         end
      end else if (m_kv && rdy) begin
         m_kv = 1'b0;
      end
      m_ovr = nov;
      m_cyc++;
   endtask

   task automatic check_all();
      chk("row_drive", row_drive, exp_rows(m_cyc));
      chk("key_valid", key_valid, m_kv);
      chk("key_code",  key_code,  m_kc);
      chk("multi_key", multi_key, m_multi);
      chk("overrun",   overrun,   m_ovr);
   endtask

   task automatic tick(input logic rdy);
      key_ready = rdy;
      @(posedge clk);
      model_edge(rdy);
      #1;
      check_all();
   endtask

   // One frame with a fixed key set; mode 0/1 fixed ready, 2 random, 3 ready only on EVAL
   task automatic run_frame(input logic [15:0] p, input logic [1:0] mode);
      pressed = p;
      for (int k = 0; k < PERIOD; k++) begin
         case (mode)
            2'd0: tick(1'b0);
            2'd1: tick(1'b1);
            2'd2: tick(($urandom % 3) == 0);
            default: tick(k == PERIOD - 1);
         endcase
      end
   endtask

   task automatic do_reset();
      key_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("rst row_drive", row_drive, 4'b0001);
      chk("rst key_valid", key_valid, 0);
      chk("rst key_code",  key_code,  0);
      chk("rst multi_key", multi_key, 0);
      chk("rst overrun",   overrun,   0);
   endtask

   initial begin
      logic [15:0] p;
      int sel, a, b;

      tbl[0]  = '{16'h0000, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{16'h0200, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[2]  = '{16'h0200, 2'd1, 1'b1, 4'd9, 1'b0, 1'b0};
      tbl[3]  = '{16'h0200, 2'd1, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[4]  = '{16'h0200, 2'd1, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[5]  = '{16'h0000, 2'd1, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[6]  = '{16'h0000, 2'd1, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[7]  = '{16'h0020, 2'd1, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[8]  = '{16'h0000, 2'd1, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[9]  = '{16'h8001, 2'd1, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[10] = '{16'h8001, 2'd1, 1'b0, 4'd9, 1'b1, 1'b0};
      tbl[11] = '{16'h8001, 2'd1, 1'b0, 4'd9, 1'b1, 1'b0};
      tbl[12] = '{16'h0000, 2'd1, 1'b0, 4'd9, 1'b1, 1'b0};
      tbl[13] = '{16'h0000, 2'd1, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[14] = '{16'h0020, 2'd0, 1'b0, 4'd9, 1'b0, 1'b0};
      tbl[15] = '{16'h0020, 2'd0, 1'b1, 4'd5, 1'b0, 1'b0};
      tbl[16] = '{16'h0000, 2'd0, 1'b1, 4'd5, 1'b0, 1'b0};
      tbl[17] = '{16'h0000, 2'd0, 1'b1, 4'd5, 1'b0, 1'b0};
      tbl[18] = '{16'h0040, 2'd0, 1'b1, 4'd5, 1'b0, 1'b0};
      tbl[19] = '{16'h0040, 2'd0, 1'b1, 4'd5, 1'b0, 1'b1};
      tbl[20] = '{16'h0040, 2'd0, 1'b1, 4'd5, 1'b0, 1'b0};
      tbl[21] = '{16'h0040, 2'd1, 1'b0, 4'd5, 1'b0, 1'b0};

      rst       = 1'b1;
      key_ready = 1'b0;
      pressed   = '0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Directed frame table: expectations sampled the cycle after each EVAL
      foreach (tbl[i]) begin
         run_frame(tbl[i].pressed, tbl[i].rdy);
         chk($sformatf("vec%0d key_valid", i), key_valid, tbl[i].exp_valid);
         chk($sformatf("vec%0d key_code", i),  key_code,  tbl[i].exp_code);
         chk($sformatf("vec%0d multi_key", i), multi_key, tbl[i].exp_multi);
         chk($sformatf("vec%0d overrun", i),   overrun,   tbl[i].exp_ovr);
      end

      // New event on the handshake cycle replaces the pending code
      run_frame(16'h0008, 2'd0);
      run_frame(16'h0008, 2'd0);
      chk("pend key_valid", key_valid, 1);
      chk("pend key_code",  key_code,  3);
      run_frame(16'h1000, 2'd0);
      run_frame(16'h1000, 2'd3);
      chk("replace key_valid", key_valid, 1);
      chk("replace key_code",  key_code,  12);
      chk("replace overrun",   overrun,   0);

      // Reset mid-frame with an event pending
      for (int k = 0; k < 6; k++) tick(1'b0);
      chk("pre-rst key_valid", key_valid, 1);
      do_reset();
      run_frame(16'h0000, 2'd1);

      // Randomized frames against the reference model
      p = '0;
      for (int f = 0; f < 80; f++) begin
         sel = $urandom_range(0, 9);
         if (sel >= 5 && sel <= 6) begin
            p = '0;
         end else if (sel >= 7 && sel <= 8) begin
            p = 16'(1) << $urandom_range(0, 15);
         end else if (sel == 9) begin
            a = $urandom_range(0, 15);
            b = (a + 1 + $urandom_range(0, 14)) % 16;
            p = (16'(1) << a) | (16'(1) << b);
         end
         run_frame(p, 2'd2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
